// File: rtl/nand4_exhaustive_tester.sv
// ---------------------------------------------------------------------------
// nand4_exhaustive_tester
//
// Exhaustive functional sequencer for one 4-input NAND cell instance. A sweep
// drives the cell inputs through all 16 combinations in ascending order. Each
// combination is held for a programmable settle time, then ZN is sampled and
// compared against the expected value. The block reports a pass/fail verdict,
// a saturating error count and the first failing vector.
//
// Parameters:
//   SETTLE_CYCLES : idle cycles between driving a vector and sampling ZN
//                   (0..255, 0 = sample on the cycle after drive)
//   ERR_W         : width of ERR_CNT
//   CHECK_INV     : 1 = expect NAND4 behaviour on ZN, 0 = expect AND4
//
// Ports:
//   CLK        in   test clock, rising edge
//   RN         in   asynchronous active-low reset
//   START      in   single-cycle sweep request, ignored while BUSY
//   ABORT      in   synchronous sweep termination, only acts while BUSY
//   A1..A4     out  cell inputs, registered, {A4,A3,A2,A1} = current vector
//   ZN         in   cell output under test
//   BUSY       out  sweep in progress
//   DONE       out  sweep completed, held until the next START
//   PASS       out  valid with DONE, 1 iff no mismatches were seen
//   ERR_CNT    out  number of mismatching vectors, saturating at all-ones
//   FAIL_VALID out  at least one mismatch captured this sweep
//   FAIL_VEC   out  first mismatching vector {A4,A3,A2,A1}
// ---------------------------------------------------------------------------
module nand4_exhaustive_tester #(
    parameter int SETTLE_CYCLES = 2,
    parameter int ERR_W         = 5,
    parameter bit CHECK_INV     = 1'b1
) (
    input  logic             CLK,
    input  logic             RN,
    input  logic             START,
    input  logic             ABORT,
    output logic             A1,
    output logic             A2,
    output logic             A3,
    output logic             A4,
    input  logic             ZN,
    output logic             BUSY,
    output logic             DONE,
    output logic             PASS,
    output logic [ERR_W-1:0] ERR_CNT,
    output logic             FAIL_VALID,
    output logic [3:0]       FAIL_VEC
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_DRIVE,
        S_SETTLE,
        S_SAMPLE,
        S_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYCLES);

    state_t           state_q;
    logic [3:0]       vec_q;
    logic [7:0]       settleCnt_q;
    logic [3:0]       drive_q;
    logic             busy_q;
    logic             done_q;
    logic             pass_q;
    logic [ERR_W-1:0] errCnt_q;
    logic             failValid_q;
    logic [3:0]       failVec_q;

    logic             expectedZn;
    logic             mismatch;
    logic [ERR_W-1:0] errCnt_d;

    // Expected cell response for the vector currently applied. A case
    // equality is used so that an X or Z on ZN is treated as a mismatch
    // rather than silently passing in simulation.
    always_comb begin
        expectedZn = CHECK_INV ? ~(&vec_q) : (&vec_q);
        mismatch   = !(ZN === expectedZn);
    end

    // Error count after the current sample, saturating at all-ones. The
    // verdict on the last vector is taken from this value so the final
    // sample is included in PASS.
    always_comb begin
        errCnt_d = errCnt_q;
        if (mismatch && (errCnt_q != '1)) begin
            errCnt_d = errCnt_q + ERR_W'(1);
        end
    end

    // Sweep sequencer. Every visible output is a flop so the cell inputs
    // never glitch. ABORT is checked before the per-state work so that a
    // same-cycle sample is discarded.
    always_ff @(posedge CLK or negedge RN) begin
        if (!RN) begin
            state_q     <= S_IDLE;
            vec_q       <= 4'h0;
            settleCnt_q <= 8'd0;
            drive_q     <= 4'h0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            pass_q      <= 1'b0;
            errCnt_q    <= '0;
            failValid_q <= 1'b0;
            failVec_q   <= 4'h0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (START) begin
                        errCnt_q    <= '0;
                        failValid_q <= 1'b0;
                        failVec_q   <= 4'h0;
                        done_q      <= 1'b0;
                        pass_q      <= 1'b0;
                        vec_q       <= 4'h0;
                        busy_q      <= 1'b1;
                        state_q     <= S_DRIVE;
                    end
                end
                S_DRIVE, S_SETTLE, S_SAMPLE: begin
                    if (ABORT) begin
                        state_q <= S_IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b0;
                        pass_q  <= 1'b0;
                        drive_q <= 4'h0;
                    end else if (state_q == S_DRIVE) begin
                        drive_q     <= vec_q;
                        settleCnt_q <= SETTLE_LOAD;
                        state_q     <= (SETTLE_CYCLES == 0) ? S_SAMPLE : S_SETTLE;
                    end else if (state_q == S_SETTLE) begin
                        // Counter was loaded with the settle time, so moving
                        // on when it reads 1 gives exactly that many cycles.
                        settleCnt_q <= settleCnt_q - 8'd1;
                        if (settleCnt_q <= 8'd1) begin
                            state_q <= S_SAMPLE;
                        end
                    end else begin
                        errCnt_q <= errCnt_d;
                        if (mismatch && !failValid_q) begin
                            failVec_q   <= vec_q;
                            failValid_q <= 1'b1;
                        end
                        if (vec_q == 4'hF) begin
                            state_q <= S_DONE;
                            busy_q  <= 1'b0;
                            done_q  <= 1'b1;
                            pass_q  <= (errCnt_d == '0);
                        end else begin
                            vec_q   <= vec_q + 4'h1;
                            state_q <= S_DRIVE;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign A1         = drive_q[0];
    assign A2         = drive_q[1];
    assign A3         = drive_q[2];
    assign A4         = drive_q[3];
    assign BUSY       = busy_q;
    assign DONE       = done_q;
    assign PASS       = pass_q;
    assign ERR_CNT    = errCnt_q;
    assign FAIL_VALID = failValid_q;
    assign FAIL_VEC   = failVec_q;

endmodule

// File: tb/tb_nand4_exhaustive_tester.sv
// ---------------------------------------------------------------------------
// tb_nand4_exhaustive_tester
//
// Four tester instances share START/ABORT/RN:
//   dut0 : defaults (settle 2), ZN source switched between golden NAND,
//          stuck-at-1 and stuck-at-0 from sweep to sweep
//   dut1 : settle 0, ZN = golden NAND delayed by one clock
//   dut2 : settle 5, ZN = golden NAND delayed by one clock
//   dut3 : ERR_W=4, CHECK_INV=0, ZN = golden NAND (every vector mismatches)
// A behavioural model derives the expected outputs from the edge count since
// START and the ZN value seen at each sample instant; it is compared every
// cycle, and hand-computed literals pin the results of each sweep.
// ---------------------------------------------------------------------------
module tb_nand4_exhaustive_tester;

    localparam int NDUT = 4;
    localparam int SETT [NDUT] = '{2, 0, 5, 2};
    localparam int ERRW [NDUT] = '{5, 5, 5, 4};
    localparam int INV  [NDUT] = '{1, 1, 1, 0};
    localparam int LAT  [NDUT] = '{64, 32, 112, 64};

    localparam int MODE_GOLD = 0;
    localparam int MODE_ONE  = 1;
    localparam int MODE_ZERO = 2;
    localparam int MODE_DLY  = 3;

    logic clk;
    logic rn;
    logic start;
    logic abort;

    logic [3:0] aOut   [NDUT];
    logic       busyO  [NDUT];
    logic       doneO  [NDUT];
    logic       passO  [NDUT];
    logic       fvO    [NDUT];
    logic [3:0] fvecO  [NDUT];
    logic [4:0] errO   [NDUT];
    logic       znArr  [NDUT];
    int         znMode [NDUT];

    int         mN     [NDUT];
    int         mErrs  [NDUT];
    int         mFirst [NDUT];
    bit         mBusy  [NDUT];
    bit         mDone  [NDUT];
    bit         mPass  [NDUT];
    logic [3:0] mA     [NDUT];

    int doneEdge [NDUT];
    bit prevDone [NDUT];
    int startEdge;
    int edgeCnt  = 0;
    int tests    = 0;
    int failures = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Device instances plus the cell model that feeds each one's ZN pin.
    for (genvar g = 0; g < NDUT; g++) begin : gDut
        logic a1, a2, a3, a4, busy, done, pass, fv, zn, znDly;
        logic [3:0]         fvec;
        logic [ERRW[g]-1:0] ec;

        always @(posedge clk) znDly <= ~(a1 & a2 & a3 & a4);

        assign zn = (znMode[g] == MODE_GOLD) ? ~(a1 & a2 & a3 & a4) :
                    (znMode[g] == MODE_ONE)  ? 1'b1 :
                    (znMode[g] == MODE_ZERO) ? 1'b0 : znDly;

        nand4_exhaustive_tester #(
            .SETTLE_CYCLES(SETT[g]),
            .ERR_W        (ERRW[g]),
            .CHECK_INV    (INV[g] != 0)
        ) dut (
            .CLK       (clk),
            .RN        (rn),
            .START     (start),
            .ABORT     (abort),
            .A1        (a1),
            .A2        (a2),
            .A3        (a3),
            .A4        (a4),
            .ZN        (zn),
            .BUSY      (busy),
            .DONE      (done),
            .PASS      (pass),
            .ERR_CNT   (ec),
            .FAIL_VALID(fv),
            .FAIL_VEC  (fvec)
        );

        assign aOut[g]  = {a4, a3, a2, a1};
        assign busyO[g] = busy;
        assign doneO[g] = done;
        assign passO[g] = pass;
        assign fvO[g]   = fv;
        assign fvecO[g] = fvec;
        assign errO[g]  = 5'(ec);
        assign znArr[g] = zn;
    end

    // One comparison: counts it and reports a FAIL line on disagreement.
    task automatic checkOutput(input string name, input int g,
                               input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("[TB] FAIL %s dut%0d: got %0h, expected %0h", name, g, act, exp);
        end
    endtask

    task automatic modelReset();
        for (int g = 0; g < NDUT; g++) begin
            mN[g] = 0; mErrs[g] = 0; mFirst[g] = -1;
            mBusy[g] = 0; mDone[g] = 0; mPass[g] = 0; mA[g] = 4'h0;
        end
    endtask

    // Advances the model across the next rising edge using the inputs and
    // ZN values that are stable just before it. Vector i is driven on edge
    // i*P+1 and sampled on edge (i+1)*P, with P = settle + 2.
    task automatic modelStep();
        int  p;
        int  i;
        bit  expZ;
        if (!rn) begin
            modelReset();
            return;
        end
        for (int g = 0; g < NDUT; g++) begin
            p = SETT[g] + 2;
            if (!mBusy[g]) begin
                if (start) begin
                    mBusy[g] = 1; mN[g] = 0; mErrs[g] = 0; mFirst[g] = -1;
                    mDone[g] = 0; mPass[g] = 0;
                end
            end else if (abort) begin
                mBusy[g] = 0; mDone[g] = 0; mPass[g] = 0; mA[g] = 4'h0;
            end else begin
                mN[g]++;
                if ((mN[g] - 1) % p == 0) mA[g] = 4'((mN[g] - 1) / p);
                if (mN[g] % p == 0) begin
                    i    = mN[g] / p - 1;
                    expZ = (INV[g] != 0) ? (i != 15) : (i == 15);
                    if (znArr[g] !== expZ) begin
                        mErrs[g]++;
                        if (mFirst[g] < 0) mFirst[g] = i;
                    end
                    if (i == 15) begin
                        mBusy[g] = 0; mDone[g] = 1; mPass[g] = (mErrs[g] == 0);
                    end
                end
            end
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    task automatic compareAll();
        int maxE;
        for (int g = 0; g < NDUT; g++) begin
            maxE = (1 << ERRW[g]) - 1;
            checkOutput("BUSY", g, 32'(busyO[g]), 32'(mBusy[g]));
            checkOutput("DONE", g, 32'(doneO[g]), 32'(mDone[g]));
            checkOutput("PASS", g, 32'(passO[g]), 32'(mPass[g]));
            checkOutput("ERR_CNT", g, 32'(errO[g]), (mErrs[g] > maxE) ? maxE : mErrs[g]);
            checkOutput("FAIL_VALID", g, 32'(fvO[g]), 32'(mFirst[g] >= 0));
            checkOutput("FAIL_VEC", g, 32'(fvecO[g]), (mFirst[g] >= 0) ? mFirst[g] : 0);
            checkOutput("A4..A1", g, 32'(aOut[g]), 32'(mA[g]));
            if (doneO[g] && !prevDone[g]) doneEdge[g] = edgeCnt;
            prevDone[g] = doneO[g];
        end
    endtask

    // One clock: compare on the falling edge, step the model, return just
    // after the rising edge where stimulus may change.
    task automatic tick();
        @(negedge clk);
        compareAll();
        modelStep();
        @(posedge clk);
        edgeCnt++;
        #1;
    endtask

    task automatic applyStimulus(input bit s, input bit a);
        start = s;
        abort = a;
        tick();
        start = 1'b0;
        abort = 1'b0;
    endtask

    function automatic bit anyBusy();
        bit b = 0;
        for (int g = 0; g < NDUT; g++) b |= busyO[g];
        return b;
    endfunction

    task automatic waitUntil(input int e);
        while (edgeCnt < e) tick();
    endtask

    task automatic waitIdle(input int budget);
        int c = 0;
        while (anyBusy() && c < budget) begin
            tick();
            c++;
        end
        checkOutput("sweepTimeout", 0, 32'(anyBusy()), 32'd0);
    endtask

    task automatic runSweep();
        for (int g = 0; g < NDUT; g++) doneEdge[g] = -1;
        applyStimulus(1'b1, 1'b0);
        startEdge = edgeCnt;
        waitIdle(300);
        tick();
    endtask

    initial begin
        rn = 1'b1; start = 1'b0; abort = 1'b0;
        znMode = '{MODE_GOLD, MODE_DLY, MODE_DLY, MODE_GOLD};
        for (int g = 0; g < NDUT; g++) begin
            doneEdge[g] = -1;
            prevDone[g] = 0;
        end
        modelReset();
        #2 rn = 1'b0;
        modelReset();
        tick();
        tick();
        checkOutput("resetBusy", 0, 32'(busyO[0]), 32'd0);
        checkOutput("resetA", 0, 32'(aOut[0]), 32'd0);
        checkOutput("resetErr", 0, 32'(errO[0]), 32'd0);
        rn = 1'b1;
        repeat (3) tick();

        // Sweep 1: golden cell on dut0, settle-time and saturation cases.
        runSweep();
        for (int g = 0; g < NDUT; g++)
            checkOutput("doneLatency", g, doneEdge[g] - startEdge, LAT[g]);
        checkOutput("goldDone", 0, 32'(doneO[0]), 32'd1);
        checkOutput("goldPass", 0, 32'(passO[0]), 32'd1);
        checkOutput("goldErr", 0, 32'(errO[0]), 32'd0);
        checkOutput("goldFailValid", 0, 32'(fvO[0]), 32'd0);
        checkOutput("goldFinalA", 0, 32'(aOut[0]), 32'hF);
        checkOutput("dlySettle0Pass", 1, 32'(passO[1]), 32'd0);
        checkOutput("dlySettle0Err", 1, 32'(errO[1]), 32'd1);
        checkOutput("dlySettle0Vec", 1, 32'(fvecO[1]), 32'hF);
        checkOutput("dlySettle5Pass", 2, 32'(passO[2]), 32'd1);
        checkOutput("satErr", 3, 32'(errO[3]), 32'd15);
        checkOutput("satPass", 3, 32'(passO[3]), 32'd0);
        checkOutput("satVec", 3, 32'(fvecO[3]), 32'h0);

        // Sweep 2: ZN stuck at 1, only vector 15 disagrees.
        znMode[0] = MODE_ONE;
        runSweep();
        checkOutput("stuck1Pass", 0, 32'(passO[0]), 32'd0);
        checkOutput("stuck1Err", 0, 32'(errO[0]), 32'd1);
        checkOutput("stuck1Vec", 0, 32'(fvecO[0]), 32'hF);
        checkOutput("stuck1Valid", 0, 32'(fvO[0]), 32'd1);

        // Sweep 3: ZN stuck at 0, vectors 0..14 disagree.
        znMode[0] = MODE_ZERO;
        runSweep();
        checkOutput("stuck0Err", 0, 32'(errO[0]), 32'd15);
        checkOutput("stuck0Vec", 0, 32'(fvecO[0]), 32'h0);
        checkOutput("stuck0Pass", 0, 32'(passO[0]), 32'd0);

        // Sweep 4: stray START at edge 10, ABORT at edge 20.
        applyStimulus(1'b1, 1'b0);
        startEdge = edgeCnt;
        waitUntil(startEdge + 9);
        applyStimulus(1'b1, 1'b0);
        waitUntil(startEdge + 19);
        applyStimulus(1'b0, 1'b1);
        checkOutput("abortBusy", 0, 32'(busyO[0]), 32'd0);
        checkOutput("abortDone", 0, 32'(doneO[0]), 32'd0);
        checkOutput("abortA", 0, 32'(aOut[0]), 32'd0);
        checkOutput("abortErr", 0, 32'(errO[0]), 32'd4);
        checkOutput("abortValid", 0, 32'(fvO[0]), 32'd1);
        repeat (3) tick();

        // Sweep 5: clean sweep after the abort.
        znMode[0] = MODE_GOLD;
        runSweep();
        checkOutput("cleanDone", 0, 32'(doneO[0]), 32'd1);
        checkOutput("cleanPass", 0, 32'(passO[0]), 32'd1);
        checkOutput("cleanErr", 0, 32'(errO[0]), 32'd0);

        // Sweep 6: asynchronous reset at edge 30, no restart without START.
        znMode[0] = MODE_ZERO;
        applyStimulus(1'b1, 1'b0);
        startEdge = edgeCnt;
        waitUntil(startEdge + 30);
        #2 rn = 1'b0;
        modelReset();
        #1;
        checkOutput("rstBusy", 0, 32'(busyO[0]), 32'd0);
        checkOutput("rstDone", 0, 32'(doneO[0]), 32'd0);
        checkOutput("rstPass", 0, 32'(passO[0]), 32'd0);
        checkOutput("rstErr", 0, 32'(errO[0]), 32'd0);
        checkOutput("rstValid", 0, 32'(fvO[0]), 32'd0);
        checkOutput("rstVec", 0, 32'(fvecO[0]), 32'd0);
        checkOutput("rstA", 0, 32'(aOut[0]), 32'd0);
        tick();
        rn = 1'b1;
        repeat (10) tick();
        checkOutput("noRestartBusy", 0, 32'(busyO[0]), 32'd0);
        checkOutput("noRestartA", 0, 32'(aOut[0]), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
